// File: rtl/axi_rd_pkg.sv
// Shared widths, FSM state encoding and AR queue entry type for axi_rd_responder.
package axi_rd_pkg;

  localparam int ADDR_BITS            = 64;
  localparam int BURST_LEN_WIDTH      = 8;
  localparam int TID_WIDTH            = 8;
  localparam int LOG_BLOCK_DATA_BYTES = 6;
  localparam int DATA_BITS            = 8 << LOG_BLOCK_DATA_BYTES;
  localparam int LOG_REQ_DEPTH        = 2;
  localparam int REQ_DEPTH            = 1 << LOG_REQ_DEPTH;
  localparam int CNT_BITS             = LOG_REQ_DEPTH + 1;
  localparam int LAT_WIDTH            = 4;
  localparam int STALL_WIDTH          = 4;
  localparam int LANE_BITS            = 64;
  localparam int NUM_LANES            = DATA_BITS / LANE_BITS;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST
  } rd_state_e;

  typedef struct packed {
    logic [ADDR_BITS-1:0]       addr;
    logic [BURST_LEN_WIDTH-1:0] len;
    logic [TID_WIDTH-1:0]       id;
  } ar_req_t;

  // Lane 0 sits in the most significant 64 bits; every lane is beatAddr + lane index.
  function automatic logic [DATA_BITS-1:0] beatData(input logic [ADDR_BITS-1:0]       base,
                                                    input logic [BURST_LEN_WIDTH-1:0] beat);
    logic [ADDR_BITS-1:0] beatAddr;
    logic [DATA_BITS-1:0] data;
    beatAddr = base + (ADDR_BITS'(beat) << LOG_BLOCK_DATA_BYTES);
    data = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      data[DATA_BITS-1-k*LANE_BITS -: LANE_BITS] = LANE_BITS'(beatAddr) + LANE_BITS'(k);
    end
    return data;
  endfunction

endpackage

// File: rtl/rd_req_fifo.sv
// In-order request queue for axi_rd_responder: synchronous FIFO of ar_req_t entries.
module rd_req_fifo
  import axi_rd_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                push_i,
  input  ar_req_t             pushData_i,
  input  logic                pop_i,
  output ar_req_t             popData_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [CNT_BITS-1:0] count_o
);

  ar_req_t                  mem_q [REQ_DEPTH];
  logic [LOG_REQ_DEPTH-1:0] wrPtr_q, rdPtr_q;
  logic [CNT_BITS-1:0]      count_q;
  logic                     doPush, doPop;

  // A full queue refuses pushes even when a pop frees a slot in the same cycle.
  assign full_o    = (count_q == CNT_BITS'(REQ_DEPTH));
  assign empty_o   = (count_q == '0);
  assign doPush    = push_i & ~full_o;
  assign doPop     = pop_i & ~empty_o;
  assign popData_o = mem_q[rdPtr_q];
  assign count_o   = count_q;

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= pushData_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read responder acting as a latency-programmable memory model with address-derived data.
// Optional per-burst beat stalling is enabled by defining AXI_RD_RESP_STALL_EN.
module axi_rd_responder
  import axi_rd_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s_ar_valid,
  output logic                       s_ar_ready,
  input  logic [BURST_LEN_WIDTH-1:0] s_ar_len,
  input  logic [ADDR_BITS-1:0]       s_ar_addr,
  input  logic [TID_WIDTH-1:0]       s_ar_id,
  output logic                       s_r_valid,
  input  logic                       s_r_ready,
  output logic                       s_r_last,
  output logic [DATA_BITS-1:0]       s_r_data,
  output logic [TID_WIDTH-1:0]       s_r_id,
  input  logic [LAT_WIDTH-1:0]       crs_latency,
`ifdef AXI_RD_RESP_STALL_EN
  input  logic [STALL_WIDTH-1:0]     crs_stallPeriod,
`endif
  output logic [CNT_BITS-1:0]        outstandingCnt
);

  rd_state_e                  state_q, state_d;
  logic [ADDR_BITS-1:0]       addr_q, addr_d;
  logic [BURST_LEN_WIDTH-1:0] len_q, len_d;
  logic [TID_WIDTH-1:0]       id_q, id_d;
  logic [LAT_WIDTH-1:0]       latCnt_q, latCnt_d;
  logic [BURST_LEN_WIDTH-1:0] beatCnt_q, beatCnt_d;

  ar_req_t             headReq;
  logic                fifoFull, fifoEmpty, fifoPop;
  logic [CNT_BITS-1:0] fifoCount;
  logic                rValid, rLast, rHs, loadHead;

  assign s_ar_ready = ~reset & ~fifoFull;

  rd_req_fifo u_reqFifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (s_ar_valid & s_ar_ready),
    .pushData_i ('{addr: s_ar_addr, len: s_ar_len, id: s_ar_id}),
    .pop_i      (fifoPop),
    .popData_o  (headReq),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty),
    .count_o    (fifoCount)
  );

`ifdef AXI_RD_RESP_STALL_EN
  logic                   bubble_q, bubble_d;
  logic [STALL_WIDTH-1:0] stallCnt_q, stallCnt_d;

  assign rValid = (state_q == BURST) & ~bubble_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_q   <= 1'b0;
      stallCnt_q <= '0;
    end else begin
      bubble_q   <= bubble_d;
      stallCnt_q <= stallCnt_d;
    end
  end
`else
  assign rValid = (state_q == BURST);
`endif

  assign rLast = rValid & (beatCnt_q == len_q);
  assign rHs   = rValid & s_r_ready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    id_d      = id_q;
    latCnt_d  = latCnt_q;
    beatCnt_d = beatCnt_q;
    loadHead  = 1'b0;
    fifoPop   = 1'b0;
`ifdef AXI_RD_RESP_STALL_EN
    bubble_d   = 1'b0;
    stallCnt_d = stallCnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!fifoEmpty) loadHead = 1'b1;
      end
      WAIT: begin
        latCnt_d = latCnt_q - 1'b1;
        if (latCnt_q == LAT_WIDTH'(1)) state_d = BURST;
      end
      BURST: begin
        if (rHs) begin
          if (rLast) begin
            if (!fifoEmpty) loadHead = 1'b1;
            else            state_d  = IDLE;
          end else begin
            beatCnt_d = beatCnt_q + 1'b1;
`ifdef AXI_RD_RESP_STALL_EN
            if (crs_stallPeriod != '0 && stallCnt_q + 1'b1 == crs_stallPeriod) begin
              bubble_d   = 1'b1;
              stallCnt_d = '0;
            end else begin
              stallCnt_d = stallCnt_q + 1'b1;
            end
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Popping the head latches crs_latency, so later changes only affect later bursts.
    if (loadHead) begin
      fifoPop   = 1'b1;
      addr_d    = headReq.addr;
      len_d     = headReq.len;
      id_d      = headReq.id;
      latCnt_d  = crs_latency;
      beatCnt_d = '0;
      state_d   = (crs_latency == '0) ? BURST : WAIT;
`ifdef AXI_RD_RESP_STALL_EN
      stallCnt_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      id_q      <= '0;
      latCnt_q  <= '0;
      beatCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      id_q      <= id_d;
      latCnt_q  <= latCnt_d;
      beatCnt_q <= beatCnt_d;
    end
  end

  assign s_r_valid = rValid;
  assign s_r_last  = rLast;
  assign s_r_id    = rValid ? id_q : '0;
  assign s_r_data  = rValid ? beatData(addr_q, beatCnt_q) : '0;

  // Queued entries plus the burst currently being waited on or returned.
  assign outstandingCnt = fifoCount + CNT_BITS'(state_q != IDLE);

endmodule

// File: tb/tb_axi_rd_responder.sv
// Self-checking bench for axi_rd_responder: directed scenarios plus a randomized scoreboard run.
module tb_axi_rd_responder;
  import axi_rd_pkg::*;

  localparam int W = DATA_BITS;

  logic                       clk;
  logic                       reset;
  logic                       s_ar_valid;
  logic                       s_ar_ready;
  logic [BURST_LEN_WIDTH-1:0] s_ar_len;
  logic [ADDR_BITS-1:0]       s_ar_addr;
  logic [TID_WIDTH-1:0]       s_ar_id;
  logic                       s_r_valid;
  logic                       s_r_ready;
  logic                       s_r_last;
  logic [DATA_BITS-1:0]       s_r_data;
  logic [TID_WIDTH-1:0]       s_r_id;
  logic [LAT_WIDTH-1:0]       crs_latency;
  logic [CNT_BITS-1:0]        outstandingCnt;

  axi_rd_responder dut (
    .clk            (clk),
    .reset          (reset),
    .s_ar_valid     (s_ar_valid),
    .s_ar_ready     (s_ar_ready),
    .s_ar_len       (s_ar_len),
    .s_ar_addr      (s_ar_addr),
    .s_ar_id        (s_ar_id),
    .s_r_valid      (s_r_valid),
    .s_r_ready      (s_r_ready),
    .s_r_last       (s_r_last),
    .s_r_data       (s_r_data),
    .s_r_id         (s_r_id),
    .crs_latency    (crs_latency),
`ifdef AXI_RD_RESP_STALL_EN
    .crs_stallPeriod(4'd0),
`endif
    .outstandingCnt (outstandingCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0]         data;
    logic [TID_WIDTH-1:0] id;
    logic                 last;
  } beat_t;

  beat_t                expQ[$];
  int                   modelOut = 0;
  bit                   holdPrev = 0;
  logic [W-1:0]         prevData;
  logic [TID_WIDTH-1:0] prevId;
  logic                 prevLast;

  // Reference beat: byte address base + beat*64 (64-bit wrap), lane k = that address + k.
  function automatic logic [W-1:0] refData(input logic [63:0] base, input int beat);
    logic [63:0] a;
    logic [W-1:0] d;
    a = base + 64'(beat) * 64'd64;
    for (int k = 0; k < 8; k++) d[W-1-64*k -: 64] = a + 64'(k);
    return d;
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Scoreboard: every visible beat must match the head of the expected stream.
  always @(negedge clk) begin
    if (reset) begin
      expQ.delete();
      modelOut = 0;
      holdPrev = 0;
    end else begin
      checkOutput("outstandingCnt", W'(outstandingCnt), W'(modelOut));
      if (holdPrev) begin
        checkOutput("holdValid", W'(s_r_valid), W'(1));
        checkOutput("holdData", s_r_data, prevData);
        checkOutput("holdId", W'(s_r_id), W'(prevId));
        checkOutput("holdLast", W'(s_r_last), W'(prevLast));
      end
      if (s_r_valid) begin
        checks++;
        assert (expQ.size() != 0)
        else begin
          errors++;
          $error("[TB] FAIL spuriousBeat observed=valid expected=no_beat_pending");
        end
        if (expQ.size() != 0) begin
          checkOutput("rData", s_r_data, expQ[0].data);
          checkOutput("rId", W'(s_r_id), W'(expQ[0].id));
          checkOutput("rLast", W'(s_r_last), W'(expQ[0].last));
          if (s_r_ready) begin
            if (expQ[0].last) modelOut--;
            void'(expQ.pop_front());
          end
        end
      end
      if (s_ar_valid && s_ar_ready) begin
        for (int b = 0; b <= int'(s_ar_len); b++) begin
          beat_t e;
          e.data = refData(s_ar_addr, b);
          e.id   = s_ar_id;
          e.last = (b == int'(s_ar_len));
          expQ.push_back(e);
        end
        modelOut++;
      end
      holdPrev = s_r_valid && !s_r_ready;
      prevData = s_r_data;
      prevId   = s_r_id;
      prevLast = s_r_last;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents one AR and returns just after its handshake edge.
  task automatic applyStimulus(input logic [63:0] addr, input logic [7:0] len, input logic [7:0] id);
    logic acc;
    acc = 1'b0;
    s_ar_addr  = addr;
    s_ar_len   = len;
    s_ar_id    = id;
    s_ar_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      acc = s_ar_ready;
      tick();
      if (acc) break;
    end
    checkOutput("arAccept", W'(acc), W'(1));
    s_ar_valid = 1'b0;
  endtask

  task automatic waitValid(output int k);
    k = -1;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (s_r_valid) begin
        k = c;
        break;
      end
    end
  endtask

  task automatic waitDrain;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (expQ.size() == 0 && !s_r_valid) break;
    end
    checkOutput("drained", W'(expQ.size()), W'(0));
    @(negedge clk);
    checkOutput("drainedCnt", W'(outstandingCnt), W'(0));
  endtask

  initial begin
    int k;
    int nAcc;
    int vCnt;
    int pat [8];
    logic acc;
    pat = '{0, 0, 1, 1, 0, 1, 1, 1};
    reset = 1'b1; s_ar_valid = 1'b0; s_ar_len = '0; s_ar_addr = '0; s_ar_id = '0;
    s_r_ready = 1'b0; crs_latency = '0;
    repeat (3) tick();
    @(negedge clk);
    checkOutput("resetArReady", W'(s_ar_ready), W'(0));
    checkOutput("resetValid", W'(s_r_valid), W'(0));
    tick();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("postResetArReady", W'(s_ar_ready), W'(1));
    checkOutput("postResetLast", W'(s_r_last), W'(0));
    checkOutput("postResetData", s_r_data, W'(0));
    checkOutput("postResetId", W'(s_r_id), W'(0));
    tick();

    // Single burst, latency 3.
    crs_latency = 4'd3; s_r_ready = 1'b1;
    applyStimulus(64'h1000, 8'd3, 8'd5);
    waitValid(k);
    checkOutput("firstBeatLatency", W'(k), W'(5));
    for (int b = 0; b < 4; b++) begin
      if (b > 0) @(negedge clk);
      checkOutput("singleValid", W'(s_r_valid), W'(1));
      checkOutput("singleLast", W'(s_r_last), W'(b == 3));
      checkOutput("singleId", W'(s_r_id), W'(5));
      checkOutput("singleCnt", W'(outstandingCnt), W'(1));
      if (b == 2) checkOutput("beat2Lane0", W'(s_r_data[511:448]), W'(64'h1080));
    end
    @(negedge clk);
    checkOutput("singleDoneValid", W'(s_r_valid), W'(0));
    checkOutput("singleDoneCnt", W'(outstandingCnt), W'(0));
    tick();

    // Back-to-back bursts, zero latency.
    crs_latency = 4'd0;
    applyStimulus(64'h4000, 8'd0, 8'd1);
    applyStimulus(64'h5000, 8'd1, 8'd2);
    waitValid(k);
    checkOutput("b2bFirst", W'(k), W'(1));
    for (int b = 0; b < 3; b++) begin
      if (b > 0) @(negedge clk);
      checkOutput("b2bValid", W'(s_r_valid), W'(1));
      checkOutput("b2bLast", W'(s_r_last), W'(b != 1));
      checkOutput("b2bId", W'(s_r_id), W'((b == 0) ? 1 : 2));
    end
    waitDrain();
    tick();

    // Full queue: one active burst plus four queued entries.
    s_r_ready = 1'b0; nAcc = 0;
    s_ar_valid = 1'b1; s_ar_len = '0; s_ar_addr = 64'h8000;
    for (int c = 0; c < 10; c++) begin
      s_ar_id = 8'(8'h20 + nAcc);
      s_ar_addr = 64'h8000 + 64'(nAcc) * 64'h100;
      @(negedge clk);
      if (s_ar_ready) nAcc++;
      tick();
    end
    checkOutput("acceptedWhenFull", W'(nAcc), W'(5));
    @(negedge clk);
    checkOutput("fullArReady", W'(s_ar_ready), W'(0));
    checkOutput("fullCnt", W'(outstandingCnt), W'(5));
    tick();
    s_r_ready = 1'b1;
    k = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      acc = s_ar_ready;
      tick();
      if (acc) begin
        k = c;
        break;
      end
    end
    checkOutput("sixthAcceptDelay", W'(k), W'(2));
    s_ar_valid = 1'b0;
    waitDrain();
    tick();

    // Backpressure mid-burst.
    crs_latency = 4'd1; s_r_ready = 1'b1;
    applyStimulus(64'h2000, 8'd3, 8'd9);
    waitValid(k);
    checkOutput("bpFirst", W'(k), W'(3));
    for (int i = 0; i < 8; i++) begin
      tick();
      s_r_ready = pat[i][0];
      if (i < 2) begin
        @(negedge clk);
        checkOutput("bpHeldLane0", W'(s_r_data[511:448]), W'(64'h2040));
      end
    end
    s_r_ready = 1'b1;
    waitDrain();
    tick();

    // Address wrap across 2^64.
    crs_latency = 4'd2;
    applyStimulus(64'hFFFF_FFFF_FFFF_FFC0, 8'd1, 8'd3);
    waitValid(k);
    checkOutput("wrapBeat0Lane0", W'(s_r_data[511:448]), W'(64'hFFFF_FFFF_FFFF_FFC0));
    @(negedge clk);
    checkOutput("wrapLast", W'(s_r_last), W'(1));
    checkOutput("wrapLane0", W'(s_r_data[511:448]), W'(64'h0));
    checkOutput("wrapLane1", W'(s_r_data[447:384]), W'(64'h1));
    waitDrain();
    tick();

    // Reset during beat 1 of an 8-beat burst with two requests queued.
    crs_latency = 4'd0; s_r_ready = 1'b0;
    applyStimulus(64'h3000, 8'd7, 8'h11);
    applyStimulus(64'h6000, 8'd2, 8'h12);
    applyStimulus(64'h7000, 8'd1, 8'h13);
    waitValid(k);
    checkOutput("rstCnt", W'(outstandingCnt), W'(3));
    tick();
    s_r_ready = 1'b1;
    tick();
    s_r_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rstBeat1Lane0", W'(s_r_data[511:448]), W'(64'h3040));
    checkOutput("rstArReady", W'(s_ar_ready), W'(0));
    tick();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rstValidAfter", W'(s_r_valid), W'(0));
    checkOutput("rstCntAfter", W'(outstandingCnt), W'(0));
    tick();
    s_r_ready = 1'b1;
    vCnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (s_r_valid) vCnt++;
    end
    checkOutput("rstNoMoreBeats", W'(vCnt), W'(0));
    tick();

    // Randomized traffic with random latency and back-pressure.
    for (int t = 0; t < 150; t++) begin
      s_ar_addr = (t % 10 == 0) ? 64'hFFFF_FFFF_FFFF_FF00 : {$urandom, $urandom};
      s_ar_len  = 8'($urandom_range(0, 7));
      s_ar_id   = 8'($urandom);
      s_ar_valid = 1'b1;
      acc = 1'b0;
      for (int c = 0; c < 500; c++) begin
        @(negedge clk);
        acc = s_ar_ready;
        tick();
        s_r_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) crs_latency = 4'($urandom_range(0, 4));
        if (acc) break;
      end
      checkOutput("randArAccept", W'(acc), W'(1));
      s_ar_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        tick();
        s_r_ready = ($urandom_range(0, 3) != 0);
      end
    end
    s_r_ready = 1'b1;
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
